// File: rtl/rf_wb_pkg.sv
// Shared constants and entry type for the register-file writeback controller.
package rf_wb_pkg;

    localparam logic [4:0]  REG_RA      = 5'd31;
    localparam logic [4:0]  REG_ZERO    = 5'd0;
    localparam logic [31:0] LINK_OFFSET = 32'd4;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } rf_wb_entry_t;

    function automatic logic [31:0] onehot_reg(input logic [4:0] a);
        return 32'd1 << a;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular FIFO of long-latency writeback entries; exposes per-slot valid and address
// so the top can build the pending-register mask.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  rf_wb_entry_t               push_entry_i,
    input  logic                       pop_i,
    output rf_wb_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [DEPTH-1:0]           valid_o,
    output logic [DEPTH-1:0][4:0]      addr_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rf_wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             do_push_s, do_pop_s;

    assign do_push_s = push_i && (count_q < CW'(DEPTH));
    assign do_pop_s  = pop_i && (count_q != CW'(0));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        if (do_pop_s) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
            valid_q  <= {DEPTH{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage needs no reset: slot contents are only observed while valid.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            addr_o[i] = mem_q[i].addr;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port arbiter merging in-order writebacks with queued long-latency results.
// Optional perf counters are enabled by defining RF_WB_PERF_EN.
module rf_writeback_ctrl
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    input  logic        wb_jal,
    output logic        wb_stall,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    output logic        rf_wen,
    output logic [4:0]  rf_addr_w,
    output logic [31:0] rf_data_w,
    output logic [31:0] pending_mask
`ifdef RF_WB_PERF_EN
    ,
    output logic [31:0] perf_lu_writes,
    output logic [31:0] perf_stall_cycles
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    rf_wb_entry_t          wb_entry_s, lu_entry_s, head_s;
    logic [CW-1:0]         count_s;
    logic [DEPTH-1:0]      fifo_valid_s;
    logic [DEPTH-1:0][4:0] fifo_addr_s;
    logic                  full_s, wb_acc_s, lu_push_s, pop_s;
    logic                  rf_wen_q, rf_wen_d;
    logic [4:0]            rf_addr_q, rf_addr_d;
    logic [31:0]           rf_data_q, rf_data_d;
    logic [31:0]           mask_s;

    assign full_s    = (count_s == CW'(DEPTH));
    assign wb_acc_s  = wb_valid && !full_s;
    assign lu_push_s = lu_valid && !full_s;
    // A full FIFO always drains, otherwise the pipeline has priority.
    assign pop_s     = full_s || (!wb_acc_s && (count_s != CW'(0)));

    assign wb_entry_s.addr = wb_jal ? REG_RA : wb_addr;
    assign wb_entry_s.data = wb_jal ? (wb_pc + LINK_OFFSET) : wb_data;
    assign lu_entry_s.addr = lu_addr;
    assign lu_entry_s.data = lu_data;

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (lu_push_s),
        .push_entry_i (lu_entry_s),
        .pop_i        (pop_s),
        .head_o       (head_s),
        .count_o      (count_s),
        .valid_o      (fifo_valid_s),
        .addr_o       (fifo_addr_s)
    );

    always_comb begin
        if (wb_acc_s) begin
            rf_wen_d  = (wb_entry_s.addr != REG_ZERO);
            rf_addr_d = wb_entry_s.addr;
            rf_data_d = wb_entry_s.data;
        end else if (pop_s) begin
            rf_wen_d  = (head_s.addr != REG_ZERO);
            rf_addr_d = head_s.addr;
            rf_data_d = head_s.data;
        end else begin
            rf_wen_d  = 1'b0;
            rf_addr_d = rf_addr_q;
            rf_data_d = rf_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen_q  <= 1'b0;
            rf_addr_q <= 5'd0;
            rf_data_q <= 32'd0;
        end else begin
            rf_wen_q  <= rf_wen_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    always_comb begin
        mask_s = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            mask_s = mask_s | (fifo_valid_s[i] ? onehot_reg(fifo_addr_s[i]) : 32'd0);
        end
        mask_s[0] = 1'b0;
    end

`ifdef RF_WB_PERF_EN
    logic [31:0] perf_lu_q, perf_stall_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_q    <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (pop_s && (perf_lu_q != 32'hFFFF_FFFF)) begin
                perf_lu_q <= perf_lu_q + 32'd1;
            end else begin
                perf_lu_q <= perf_lu_q;
            end
            if (full_s && wb_valid && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end else begin
                perf_stall_q <= perf_stall_q;
            end
        end
    end

    assign perf_lu_writes    = perf_lu_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

    assign wb_stall     = full_s;
    assign lu_ready     = !full_s;
    assign rf_wen       = rf_wen_q;
    assign rf_addr_w    = rf_addr_q;
    assign rf_data_w    = rf_data_q;
    assign pending_mask = mask_s;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Randomized self-checking bench for rf_writeback_ctrl with a queue-based reference model.
module tb_rf_writeback_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, wb_jal, lu_valid;
    logic [4:0]  wb_addr, lu_addr;
    logic [31:0] wb_data, wb_pc, lu_data;
    logic        wb_stall, lu_ready, rf_wen;
    logic [4:0]  rf_addr_w;
    logic [31:0] rf_data_w, pending_mask;
`ifdef RF_WB_PERF_EN
    logic [31:0] perf_lu_writes, perf_stall_cycles;
    int unsigned m_perf_lu = 0, m_perf_stall = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0]  qa [$];
    logic [31:0] qd [$];

    always #5 clk = ~clk;

    rf_writeback_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_pc        (wb_pc),
        .wb_jal       (wb_jal),
        .wb_stall     (wb_stall),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_addr      (lu_addr),
        .lu_data      (lu_data),
        .rf_wen       (rf_wen),
        .rf_addr_w    (rf_addr_w),
        .rf_data_w    (rf_data_w),
        .pending_mask (pending_mask)
`ifdef RF_WB_PERF_EN
        ,
        .perf_lu_writes    (perf_lu_writes),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check state-derived outputs, predict and check rf_*.
    task automatic step(input logic r, input logic wv, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [31:0] wpc, input logic jl,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
        logic        full, wacc, push, pop, e_wen;
        logic [4:0]  e_a;
        logic [31:0] e_d, pmask;
        rst = r; wb_valid = wv; wb_addr = wa; wb_data = wd; wb_pc = wpc; wb_jal = jl;
        lu_valid = lv; lu_addr = la; lu_data = ld;
        #1;
        full  = (qa.size() == DEPTH);
        pmask = 32'd0;
        foreach (qa[i]) if (qa[i] != 5'd0) pmask[qa[i]] = 1'b1;
        check_eq("wb_stall", 32'(wb_stall), 32'(full));
        check_eq("lu_ready", 32'(lu_ready), 32'(!full));
        check_eq("pending_mask", pending_mask, pmask);
        e_wen = 1'b0; e_a = 5'd0; e_d = 32'd0;
        if (r) begin
            qa.delete(); qd.delete();
`ifdef RF_WB_PERF_EN
            m_perf_lu = 0; m_perf_stall = 0;
`endif
        end else begin
            wacc = wv && !full;
            push = lv && !full;
            pop  = full || (!wacc && qa.size() != 0);
            if (wacc) begin
                e_a = jl ? 5'd31 : wa;
                e_d = jl ? (wpc + 32'd4) : wd;
                e_wen = (e_a != 5'd0);
            end else if (pop) begin
                e_a = qa[0]; e_d = qd[0];
                e_wen = (e_a != 5'd0);
            end
            if (pop) begin
                void'(qa.pop_front()); void'(qd.pop_front());
            end
            if (push) begin
                qa.push_back(la); qd.push_back(ld);
            end
`ifdef RF_WB_PERF_EN
            if (pop) m_perf_lu++;
            if (full && wv) m_perf_stall++;
`endif
        end
        @(posedge clk); #1;
        check_eq("rf_wen", 32'(rf_wen), 32'(e_wen));
        if (e_wen || r) begin
            check_eq("rf_addr_w", 32'(rf_addr_w), 32'(e_a));
            check_eq("rf_data_w", rf_data_w, e_d);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; wb_pc = 32'd0;
        wb_jal = 1'b0; lu_valid = 1'b0; lu_addr = 5'd0; lu_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rf_wen", 32'(rf_wen), 32'd0);
        check_eq("rst_rf_addr", 32'(rf_addr_w), 32'd0);
        check_eq("rst_rf_data", rf_data_w, 32'd0);
        check_eq("rst_pending", pending_mask, 32'd0);
        check_eq("rst_lu_ready", 32'(lu_ready), 32'd1);
        check_eq("rst_wb_stall", 32'(wb_stall), 32'd0);
        rst = 1'b0;

        // Plain writeback with latency 1.
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0000_1000, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("wb_basic_data", rf_data_w, 32'hDEAD_BEEF);
        // JAL link value wraps past 2^32.
        step(1'b0, 1'b1, 5'd7, 32'h1234_5678, 32'hFFFF_FFFC, 1'b1, 1'b0, 5'd0, 32'd0);
        check_eq("jal_addr", 32'(rf_addr_w), 32'd31);
        check_eq("jal_data", rf_data_w, 32'h0000_0000);

        // Long-latency result with wb idle.
        step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd9, 32'h11);
        check_eq("lu9_pending_set", 32'(pending_mask[9]), 32'd1);
        idle();
        check_eq("lu9_write", {rf_wen, rf_addr_w, rf_data_w[25:0]}, {1'b1, 5'd9, 26'h11});
        check_eq("lu9_pending_clr", 32'(pending_mask[9]), 32'd0);

        // Fill FIFO while wb busy every cycle, then keep wb busy across the stall.
        for (int i = 1; i <= 4; i++)
            step(1'b0, 1'b1, 5'(10 + i), 32'(i), 32'd0, 1'b0, 1'b1, 5'(i), 32'(100 + i));
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 5'(20 + i), 32'(200 + i), 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (6) idle();

        // r0 destinations never write.
        step(1'b0, 1'b1, 5'd0, 32'h5, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 32'h77);
        repeat (2) idle();

        // Reset with entries queued discards them.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'd3, 32'(i), 32'd0, 1'b0, 1'b1, 5'(i + 2), 32'(i));
        step(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (3) idle();
        check_eq("post_rst_lu_ready", 32'(lu_ready), 32'd1);
        check_eq("post_rst_pending", pending_mask, 32'd0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 64) == 0, ($urandom % 3) != 0, 5'($urandom % 32), $urandom,
                 (($urandom % 4) == 0) ? 32'hFFFF_FFFC : $urandom, ($urandom % 8) == 0,
                 ($urandom % 3) != 0, 5'($urandom % 32), $urandom);
        end
        repeat (6) idle();
`ifdef RF_WB_PERF_EN
        check_eq("perf_lu_writes", perf_lu_writes, m_perf_lu);
        check_eq("perf_stall_cycles", perf_stall_cycles, m_perf_stall);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
